// File: rtl/matmul_host_ctrl.sv
// rtl/matmul_host_ctrl.sv - byte-stream host initiator for the 2x2 matrix multiplier start/done port
// Define MMHOST_TIMEOUT_EN to enable the WAIT-state watchdog (err pulse, 16'hFFFF results).
module matmul_host_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        m_valid,
  output logic [15:0] m_data,
  output logic        m_last,
  input  logic        m_ready,
  output logic        mm_start,
  output logic [7:0]  mm_a11,
  output logic [7:0]  mm_a12,
  output logic [7:0]  mm_a21,
  output logic [7:0]  mm_a22,
  output logic [7:0]  mm_b11,
  output logic [7:0]  mm_b12,
  output logic [7:0]  mm_b21,
  output logic [7:0]  mm_b22,
  input  logic [15:0] mm_c11,
  input  logic [15:0] mm_c12,
  input  logic [15:0] mm_c21,
  input  logic [15:0] mm_c22,
  input  logic        mm_done,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {COLLECT, KICK, WAIT, SEND} state_t;

  state_t            state_q, state_d;
  logic [2:0]        byte_idx_q, byte_idx_d;
  logic [1:0]        word_idx_q, word_idx_d;
  logic [7:0][7:0]   op_q, op_d;
  logic [3:0][15:0]  res_q, res_d;
  logic              s_ready_q, s_ready_d;
  logic              m_valid_q, m_valid_d;
  logic              byte_acc;
  logic              word_acc;
  logic              timeout;

  assign byte_acc = s_valid && s_ready_q && (state_q == COLLECT);
  assign word_acc = m_valid_q && m_ready && (state_q == SEND);

`ifdef MMHOST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_q, err_d;

  // Counter restarts from zero on every entry to WAIT; mm_done wins a same-cycle tie.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == WAIT) tmo_cnt_d = tmo_cnt_q + CW'(1);
  end

  assign timeout = (state_q == WAIT) && !mm_done && (tmo_cnt_q == CW'(TIMEOUT - 1));
  assign err_d   = timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      op_q       <= '0;
      res_q      <= '0;
      s_ready_q  <= 1'b0;
      m_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      op_q       <= op_d;
      res_q      <= res_d;
      s_ready_q  <= s_ready_d;
      m_valid_q  <= m_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (byte_acc && (byte_idx_q == 3'd7)) state_d = KICK;
      KICK:    state_d = WAIT;
      WAIT:    if (mm_done || timeout) state_d = SEND;
      SEND:    if (word_acc && (word_idx_q == 2'd3)) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_comb begin
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    op_d       = op_q;
    res_d      = res_q;
    m_valid_d  = m_valid_q;
    // s_ready is a flop, so it looks one state ahead to drop on the byte-7 edge.
    s_ready_d  = (state_d == COLLECT);

    if (byte_acc) begin
      op_d[byte_idx_q] = s_data;
      byte_idx_d       = byte_idx_q + 3'd1;
    end

    if (state_q == WAIT) begin
      if (mm_done) begin
        res_d     = {mm_c22, mm_c21, mm_c12, mm_c11};
        m_valid_d = 1'b1;
        word_idx_d = 2'd0;
      end else if (timeout) begin
        res_d     = {4{16'hFFFF}};
        m_valid_d = 1'b1;
        word_idx_d = 2'd0;
      end
    end

    if (word_acc) begin
      word_idx_d = word_idx_q + 2'd1;
      if (word_idx_q == 2'd3) m_valid_d = 1'b0;
    end
  end

  always_comb begin
    mm_start = (state_q == KICK);
    busy     = (state_q != COLLECT) || (byte_idx_q != 3'd0);
    m_data   = res_q[word_idx_q];
    m_last   = m_valid_q && (word_idx_q == 2'd3);
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign mm_a11  = op_q[0];
  assign mm_a12  = op_q[1];
  assign mm_a21  = op_q[2];
  assign mm_a22  = op_q[3];
  assign mm_b11  = op_q[4];
  assign mm_b12  = op_q[5];
  assign mm_b21  = op_q[6];
  assign mm_b22  = op_q[7];

endmodule

// File: tb/tb_matmul_host_ctrl.sv
// tb/tb_matmul_host_ctrl.sv - scoreboard bench for matmul_host_ctrl with a stub 4-cycle multiplier
`timescale 1ns/1ps
module tb_matmul_host_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid, s_ready, m_valid, m_last, m_ready, mm_start, mm_done, busy, err;
  logic [7:0]  s_data;
  logic [15:0] m_data;
  logic [7:0]  mm_a11, mm_a12, mm_a21, mm_a22, mm_b11, mm_b12, mm_b21, mm_b22;
  logic [15:0] mm_c11, mm_c12, mm_c21, mm_c22;

  always #5 clk = ~clk;

  matmul_host_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .mm_start(mm_start),
    .mm_a11(mm_a11), .mm_a12(mm_a12), .mm_a21(mm_a21), .mm_a22(mm_a22),
    .mm_b11(mm_b11), .mm_b12(mm_b12), .mm_b21(mm_b21), .mm_b22(mm_b22),
    .mm_c11(mm_c11), .mm_c12(mm_c12), .mm_c21(mm_c21), .mm_c22(mm_c22),
    .mm_done(mm_done), .busy(busy), .err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Multiplier stub: done 4 cycles after the start cycle; results are garbage outside done.
  logic        model_en = 1'b1;
  logic        spur = 1'b0;
  logic [3:0]  sh;
  logic [15:0] p11, p12, p21, p22;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) sh <= '0;
    else        sh <= {sh[2:0], mm_start & model_en};

  always @(posedge clk)
    if (mm_start) begin
      p11 <= 16'(mm_a11) * 16'(mm_b11) + 16'(mm_a12) * 16'(mm_b21);
      p12 <= 16'(mm_a11) * 16'(mm_b12) + 16'(mm_a12) * 16'(mm_b22);
      p21 <= 16'(mm_a21) * 16'(mm_b11) + 16'(mm_a22) * 16'(mm_b21);
      p22 <= 16'(mm_a21) * 16'(mm_b12) + 16'(mm_a22) * 16'(mm_b22);
    end

  assign mm_done = sh[3] | spur;
  assign mm_c11  = sh[3] ? p11 : 16'hDEAD;
  assign mm_c12  = sh[3] ? p12 : 16'hBEEF;
  assign mm_c21  = sh[3] ? p21 : 16'hCAFE;
  assign mm_c22  = sh[3] ? p22 : 16'hF00D;

  // Downstream ready driver.
  logic rdy_toggle = 1'b0;
  logic rdy_hold = 1'b1;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = rdy_toggle ? ~m_ready : rdy_hold;
    end
  end

  // Scoreboard monitor.
  typedef struct packed { logic [15:0] d; logic l; } exp_t;
  exp_t q[$];
  int   words_seen = 0;
  int   starts = 0;
  int   errs_seen = 0;
  logic held_v = 1'b0;
  logic [15:0] held_d;
  logic held_l;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (mm_start) starts++;
      if (err) errs_seen++;
      if (held_v && m_valid) begin
        check("stall_data", m_data, held_d);
        check("stall_last", m_last, held_l);
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %0h, expected no word", m_data);
        end else begin
          e = q.pop_front();
          check("word_data", m_data, e.d);
          check("word_last", m_last, e.l);
        end
        words_seen++;
      end
      held_v = m_valid && !m_ready;
      held_d = m_data;
      held_l = m_last;
    end
  end

  task automatic push4(input logic [15:0] c11, c12, c21, c22);
    exp_t e;
    e.d = c11; e.l = 1'b0; q.push_back(e);
    e.d = c12; e.l = 1'b0; q.push_back(e);
    e.d = c21; e.l = 1'b0; q.push_back(e);
    e.d = c22; e.l = 1'b1; q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    s_valid = 1'b1;
    s_data  = b;
    @(negedge clk);
    while (!s_ready && n < 2000) begin @(negedge clk); n++; end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL s_ready_wait: s_ready stayed 0, expected 1");
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // Ends #1 after the edge that accepts byte 7 and checks the KICK cycle.
  task automatic send_set(input logic [7:0] a11, a12, a21, a22, b11, b12, b21, b22, input int gap);
    send_byte(a11, gap); send_byte(a12, gap); send_byte(a21, gap); send_byte(a22, gap);
    send_byte(b11, gap); send_byte(b12, gap); send_byte(b21, gap); send_byte(b22, 0);
    check("kick_start", mm_start, 1);
    check("kick_s_ready", s_ready, 0);
    check("kick_busy", busy, 1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!m_valid && lat < 2000) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || m_valid) && n < 500) begin @(posedge clk); #1; n++; end
    check("drain_queue", q.size(), 0);
    check("drain_busy", busy, 0);
  endtask

  task automatic check_reset();
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_mm_start", mm_start, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_ops_a", {mm_a11, mm_a12, mm_a21, mm_a22}, 0);
    check("rst_ops_b", {mm_b11, mm_b12, mm_b21, mm_b22}, 0);
  endtask

  task automatic do_set(input logic [7:0] a11, a12, a21, a22, b11, b12, b21, b22,
                        input int gap, input logic [15:0] c11, c12, c21, c22);
    int lat;
    int st0;
    st0 = starts;
    push4(c11, c12, c21, c22);
    send_set(a11, a12, a21, a22, b11, b12, b21, b22, gap);
    wait_valid(lat);
    check("first_word_latency", lat, 5);
    wait_drain();
    check("start_pulses", starts - st0, 1);
  endtask

  initial begin
    int lat;
    int ws0;
    int es0;
    s_valid = 1'b0;
    s_data  = '0;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("s_ready_after_release", s_ready, 1);

    do_set(1, 2, 3, 4, 5, 6, 7, 8, 0, 16'd19, 16'd22, 16'd43, 16'd50);
    do_set(255, 255, 255, 255, 255, 255, 255, 255, 0, 16'hFC02, 16'hFC02, 16'hFC02, 16'hFC02);

    rdy_toggle = 1'b1;
    do_set(1, 2, 3, 4, 5, 6, 7, 8, 1, 16'd19, 16'd22, 16'd43, 16'd50);
    rdy_toggle = 1'b0;
    rdy_hold   = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Spurious mm_done in COLLECT and in a stalled SEND.
    push4(16'd2, 16'd4, 16'd6, 16'd8);
    es0 = starts;
    send_byte(2, 0); send_byte(0, 0); send_byte(0, 0); send_byte(2, 0);
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    check("spur_collect_s_ready", s_ready, 1);
    check("spur_collect_busy", busy, 1);
    rdy_hold = 1'b0;
    send_byte(1, 0); send_byte(2, 0); send_byte(3, 0); send_byte(4, 0);
    wait_valid(lat);
    check("spur_first_latency", lat, 5);
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("spur_send_valid", m_valid, 1);
    check("spur_send_data", m_data, 2);
    check("spur_send_busy", busy, 1);
    rdy_hold = 1'b1;
    wait_drain();
    check("spur_start_pulses", starts - es0, 1);

    // Reset while in WAIT.
    send_set(1, 2, 3, 4, 5, 6, 7, 8, 0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_reset();
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("post_wait_reset_valid", m_valid, 0);
    do_set(1, 2, 3, 4, 5, 6, 7, 8, 0, 16'd19, 16'd22, 16'd43, 16'd50);

    // Reset while word index 2 is presented.
    push4(16'd9, 16'd8, 16'd7, 16'd6);
    ws0 = words_seen;
    send_set(1, 0, 0, 1, 9, 8, 7, 6, 0);
    lat = 0;
    while (words_seen < ws0 + 2 && lat < 200) begin @(posedge clk); #1; lat++; end
    check("send_idx2_words", words_seen - ws0, 2);
    check("send_idx2_data", m_data, 7);
    rst_n = 1'b0;
    q.delete();
    #1;
    check_reset();
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_set(2, 0, 0, 2, 1, 2, 3, 4, 0, 16'd2, 16'd4, 16'd6, 16'd8);

    // Multiplier never answers.
    model_en = 1'b0;
    es0 = errs_seen;
`ifdef MMHOST_TIMEOUT_EN
    push4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    send_set(1, 2, 3, 4, 5, 6, 7, 8, 0);
    lat = 0;
    while (!err && lat < 2000) begin @(posedge clk); #1; lat++; end
    check("timeout_err_latency", lat, 17);
    check("timeout_m_valid", m_valid, 1);
    @(posedge clk); #1;
    check("timeout_err_single", err, 0);
    wait_drain();
    check("timeout_err_pulses", errs_seen - es0, 1);
`else
    send_set(1, 2, 3, 4, 5, 6, 7, 8, 0);
    repeat (1000) begin @(posedge clk); #1; end
    check("hang_m_valid", m_valid, 0);
    check("hang_busy", busy, 1);
    check("hang_s_ready", s_ready, 0);
    check("hang_err_pulses", errs_seen - es0, 0);
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
`endif
    model_en = 1'b1;
    do_set(1, 2, 3, 4, 5, 6, 7, 8, 0, 16'd19, 16'd22, 16'd43, 16'd50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/matmul_host_ctrl.md
# matmul_host_ctrl

Host-side initiator for the 2x2 matrix multiplier's start/done interface. It accepts eight 8-bit operands as a byte stream, presents them as a parallel matrix A/B, pulses start, and waits for done. It then captures the four 16-bit results and returns them as a word stream. It sits between a byte-oriented front end (UART/bus bridge) and the multiplier core.

## Interface
- TIMEOUT, 16: max cycles spent in WAIT before watchdog fires (only with MMHOST_TIMEOUT_EN)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  input byte valid
- s_data  in  8  input byte
- s_ready  out  1  input byte accepted when s_valid&s_ready
- m_valid  out  1  result word valid
- m_data  out  16  result word
- m_last  out  1  high with the final word (c22)
- m_ready  in  1  downstream accepts word when m_valid&m_ready
- mm_start  out  1  one-cycle start pulse to multiplier
- mm_a11, mm_a12, mm_a21, mm_a22, mm_b11, mm_b12, mm_b21, mm_b22  out  8 each  operands to multiplier
- mm_c11, mm_c12, mm_c21, mm_c22  in  16 each  results from multiplier
- mm_done  in  1  multiplier completion pulse
- busy  out  1  high whenever state != COLLECT or a partial operand set is held
- err  out  1  one-cycle pulse on watchdog expiry (tied 0 without MMHOST_TIMEOUT_EN)

## Operation
- States: COLLECT, KICK, WAIT, SEND. Reset state COLLECT.
- COLLECT: 3-bit byte index 0..7; bytes land in order a11,a12,a21,a22,b11,b12,b21,b22. On accepting index 7: s_ready drops, go KICK.
- KICK: mm_start=1 for exactly this cycle; go WAIT.
- WAIT: on mm_done=1 capture mm_c11..c22 into internal result regs same edge; go SEND.
- SEND: word index 0..3 emits c11,c12,c21,c22; m_last=1 on index 3. After index 3 handshake: m_valid drops, index cleared, s_ready rises, go COLLECT.
- mm_a*/mm_b* are registered, change only on COLLECT byte accepts, and are stable from KICK until the next COLLECT accept.
- mm_done outside WAIT is ignored. mm_start never asserted outside KICK.
- Results passed through unmodified (multiplier truncates to 16 bits; no saturation here).
- m_valid, once high, stays high and m_data/m_last stay stable until m_ready.
- Reset values: s_ready=0, m_valid=0, m_data=0, m_last=0, mm_start=0, all mm_a*/mm_b*=0, busy=0, err=0; byte/word indices 0; result regs 0.
- Reset mid-operation: all in-flight operands/results discarded, return to COLLECT with index 0. The multiplier shares rst_n.

## Timing
- s_ready registered. It is 1 on the first cycle after reset release and in COLLECT, and 0 from the edge accepting byte 7 until SEND completes.
- No combinational path from s_valid to s_ready or from m_ready to m_valid.
- Byte 7 accepted at edge E: KICK during cycle E..E+1 (mm_start high), WAIT from E+1.
- With the multiplier core, mm_done arrives 4 cycles after the mm_start cycle. The first m_valid follows 1 cycle after the mm_done cycle.
- Min end-to-end: 8 input cycles + 1 KICK + 4 WAIT + 4 output cycles (m_ready held 1).
- Back-to-back: first byte of the next set accepted the cycle after the c22 handshake.

## Configuration
- MMHOST_TIMEOUT_EN defined:
  - Cycle counter runs in WAIT.
  - If mm_done is not seen within TIMEOUT cycles of entering WAIT, err pulses 1 cycle and results load as 16'hFFFF x4, then go SEND.
  - A late mm_done is ignored.
- Undefined: no counter; WAIT holds indefinitely; err constant 0.

## Test plan
- A=[1,2;3,4], B=[5,6;7,8], s_valid and m_ready held high -> mm_start single pulse; outputs 19,22,43,50; m_last only on 50; busy low after.
- All operands 255 -> each output 130050 mod 65536 = 64514 (0xFC02).
- s_valid gapped every other cycle plus m_ready toggled 1010 -> same values as the first test, no duplicated or dropped words, m_data stable while stalled.
- Spurious mm_done pulses during COLLECT and SEND -> no state change, no result overwrite.
- rst_n asserted during WAIT and again at SEND index 2 -> all outputs return to reset values; next full operand set produces correct results.
- MMHOST_TIMEOUT_EN with mm_done tied 0, TIMEOUT=16 -> err pulse 16 cycles after entering WAIT; outputs 0xFFFF x4. Without the macro -> still in WAIT after 1000 cycles, err=0.
